// File: rtl/sodor_mem_pkg.sv
// sodor_mem_pkg
// Shared constants for the Sodor data-memory responder: memory function
// codes (load/store), access-type codes, the responder FSM state enum and
// helpers that normalise access types and detect faulting accesses.
package sodor_mem_pkg;

  // Memory function codes.
  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  // Access-type codes.
  localparam logic [2:0] MT_B  = 3'b001;
  localparam logic [2:0] MT_H  = 3'b010;
  localparam logic [2:0] MT_W  = 3'b011;
  localparam logic [2:0] MT_BU = 3'b101;
  localparam logic [2:0] MT_HU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Unknown type codes behave as full-word accesses.
  function automatic logic [2:0] norm_typ(input logic [2:0] typ);
    case (typ)
      MT_B, MT_H, MT_BU, MT_HU: return typ;
      default:                  return MT_W;
    endcase
  endfunction

  // Misaligned half/word access, or word index beyond the array.
  function automatic logic access_err(input logic [31:0]  addr,
                                      input logic [2:0]   typ,
                                      input int unsigned  depth);
    logic [2:0] t;
    logic       misal;
    logic       oor;
    t     = norm_typ(typ);
    misal = (((t == MT_H) || (t == MT_HU)) && addr[0]) ||
            ((t == MT_W) && (addr[1:0] != 2'b00));
    oor   = ({2'b00, addr[31:2]} >= depth);
    return misal | oor;
  endfunction

endpackage

// File: rtl/sodor_lane_fmt.sv
// sodor_lane_fmt
// Combinational byte-lane formatter shared by the store and load paths.
// Ports:
//   st_off_i   byte offset (addr[1:0]) of the store
//   st_typ_i   store access type
//   st_old_i   current contents of the addressed word
//   st_wdata_i LSB-aligned store data
//   st_word_o  word with the selected lanes replaced
//   ld_off_i   byte offset (addr[1:0]) of the load
//   ld_typ_i   load access type
//   ld_word_i  word read from memory
//   ld_data_o  selected lanes, sign- or zero-extended
module sodor_lane_fmt
  import sodor_mem_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [2:0]  st_typ_i,
  input  logic [31:0] st_old_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_word_o,
  input  logic [1:0]  ld_off_i,
  input  logic [2:0]  ld_typ_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [2:0]  st_t;
  logic [2:0]  ld_t;
  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  always_comb begin
    st_t      = norm_typ(st_typ_i);
    st_word_o = st_old_i;
    case (st_t)
      MT_B, MT_BU: st_word_o[{st_off_i, 3'b000} +: 8]     = st_wdata_i[7:0];
      MT_H, MT_HU: st_word_o[{st_off_i[1], 4'b0000} +: 16] = st_wdata_i[15:0];
      default:     st_word_o = st_wdata_i;
    endcase
  end

  always_comb begin
    ld_t   = norm_typ(ld_typ_i);
    b_lane = ld_word_i[{ld_off_i, 3'b000} +: 8];
    h_lane = ld_word_i[{ld_off_i[1], 4'b0000} +: 16];
    case (ld_t)
      MT_B:    ld_data_o = {{24{b_lane[7]}}, b_lane};
      MT_BU:   ld_data_o = {24'd0, b_lane};
      MT_H:    ld_data_o = {{16{h_lane[15]}}, h_lane};
      MT_HU:   ld_data_o = {16'd0, h_lane};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/sodor_dmem_responder.sv
// sodor_dmem_responder
// Fixed-latency data-memory responder for the Sodor core. Accepts one
// request at a time, commits stores at the acceptance edge and returns a
// one-cycle response LATENCY cycles after acceptance.
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        synchronous reset, active low
//   req_valid_i   request valid
//   req_ready_o   responder idle and able to accept
//   req_addr_i    byte address
//   req_wdata_i   LSB-aligned store data
//   req_fcn_i     1 = store, 0 = load
//   req_typ_i     access type (B/H/W/BU/HU)
//   resp_valid_o  one-cycle response pulse
//   resp_data_o   load result (0 for stores, faults and idle cycles)
//   resp_err_o    access faulted (only with resp_valid_o)
//
// state   | meaning
// IDLE    | ready for a request
// WAIT    | request accepted, counting towards the response cycle
// RESP    | response presented for one cycle
module sodor_dmem_responder
  import sodor_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_fcn_i,
  input  logic [2:0]  req_typ_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_LAST = 4'(LATENCY - 1);

  dmem_state_e   state_q;
  logic [3:0]    cnt_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  // Request captured at acceptance. Store data is consumed by the array
  // write on that same edge, so it needs no holding register.
  logic [31:0]   addr_q;
  logic          fcn_q;
  logic [2:0]    typ_q;
  logic [31:0]   rword_q;

  logic          accept;
  logic          acc_err;
  logic          rsp_err;
  logic [AW-1:0] acc_idx;
  logic [31:0]   st_word;
  logic [31:0]   ld_data;

  assign req_ready_o = rst_ni && (state_q == ST_IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign acc_idx     = req_addr_i[AW+1:2];
  assign acc_err     = access_err(req_addr_i, req_typ_i, DEPTH_WORDS);
  assign rsp_err     = access_err(addr_q, typ_q, DEPTH_WORDS);

  sodor_lane_fmt u_lane_fmt (
    .st_off_i   (req_addr_i[1:0]),
    .st_typ_i   (req_typ_i),
    .st_old_i   (mem_q[acc_idx]),
    .st_wdata_i (req_wdata_i),
    .st_word_o  (st_word),
    .ld_off_i   (addr_q[1:0]),
    .ld_typ_i   (typ_q),
    .ld_word_i  (rword_q),
    .ld_data_o  (ld_data)
  );

  // The array is deliberately not reset. A faulting store is dropped, so an
  // out-of-range address cannot alias onto a low word through acc_idx.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q  <= req_addr_i;
      fcn_q   <= req_fcn_i;
      typ_q   <= req_typ_i;
      rword_q <= mem_q[acc_idx];
      if ((req_fcn_i == M_XWR) && !acc_err) begin
        mem_q[acc_idx] <= st_word;
      end
    end
  end

  // cnt_q holds the number of cycles elapsed since acceptance.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q   <= 4'd1;
            state_q <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == LAT_LAST) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Response fields are decoded from registered state only.
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_err_o   = resp_valid_o && rsp_err;
  assign resp_data_o  = (resp_valid_o && !rsp_err && (fcn_q == M_XRD)) ? ld_data : 32'd0;

endmodule

// File: tb/tb_sodor_dmem_responder.sv
module tb_sodor_dmem_responder;
  import sodor_mem_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  valid;
  logic [31:0] addr, wdata;
  logic        fcn;
  logic [2:0]  typ;
  logic [1:0]  ready, rvalid, rerr;
  logic [31:0] rdata0, rdata1;

  // dut0: default latency 2, dut1: latency 1. Request fields are shared;
  // only one DUT is driven at a time.
  sodor_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid[0]), .req_ready_o(ready[0]),
    .req_addr_i(addr), .req_wdata_i(wdata), .req_fcn_i(fcn), .req_typ_i(typ),
    .resp_valid_o(rvalid[0]), .resp_data_o(rdata0), .resp_err_o(rerr[0]));

  sodor_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid[1]), .req_ready_o(ready[1]),
    .req_addr_i(addr), .req_wdata_i(wdata), .req_fcn_i(fcn), .req_typ_i(typ),
    .resp_valid_o(rvalid[1]), .resp_data_o(rdata1), .resp_err_o(rerr[1]));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  int LAT [2]        = '{2, 1};
  int acc_cnt [2]    = '{0, 0};
  int last_acc [2]   = '{0, 0};
  int last_resp [2]  = '{-100, -100};
  int pulse_cnt [2]  = '{0, 0};
  int busy_until [2] = '{-1, -1};
  int acc_hist [$];

  bit [31:0] mdl [2][256];
  logic [31:0] last_exp_data;
  logic        last_exp_err;

  typedef struct {
    bit          d;
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t pq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Byte-addressed reference: an access touches `size` consecutive bytes.
  function automatic void model(input bit d, input logic f, input logic [2:0] t_in,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] data, output logic err);
    logic [2:0]  t;
    logic [31:0] v;
    logic [31:0] ba;
    int          sz;
    t = ((t_in == MT_B) || (t_in == MT_H) || (t_in == MT_BU) || (t_in == MT_HU)) ? t_in : MT_W;
    sz = ((t == MT_B) || (t == MT_BU)) ? 1 : ((t == MT_H) || (t == MT_HU)) ? 2 : 4;
    err  = ((a % 32'(sz)) != 32'd0) || ((a >> 2) >= 32'd256);
    data = 32'd0;
    if (err) return;
    if (f) begin
      for (int i = 0; i < sz; i++) begin
        ba = a + 32'(i);
        mdl[d][ba[9:2]][{ba[1:0], 3'b000} +: 8] = wd[8*i +: 8];
      end
    end else begin
      v = 32'd0;
      for (int i = 0; i < sz; i++) begin
        ba = a + 32'(i);
        v[8*i +: 8] = mdl[d][ba[9:2]][{ba[1:0], 3'b000} +: 8];
      end
      if ((t == MT_B) && v[7])  v = v | 32'hFFFF_FF00;
      if ((t == MT_H) && v[15]) v = v | 32'hFFFF_0000;
      data = v;
    end
  endfunction

  // Single compare process: checks every output of both DUTs each cycle and
  // advances the reference model when a request is accepted.
  logic        c_er, c_ev, c_ee, m_e;
  logic [31:0] c_ed, c_ad, m_d;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        c_er = rst_n && (cyc > busy_until[d]);
        c_ev = (pq.size() > 0) && (pq[0].d == d[0]) && (pq[0].due == cyc);
        c_ed = c_ev ? pq[0].data : 32'd0;
        c_ee = c_ev ? pq[0].err : 1'b0;
        c_ad = (d == 0) ? rdata0 : rdata1;
        chk($sformatf("req_ready%0d", d), {31'd0, ready[d]}, {31'd0, c_er});
        chk($sformatf("resp_valid%0d", d), {31'd0, rvalid[d]}, {31'd0, c_ev});
        chk($sformatf("resp_data%0d", d), c_ad, c_ed);
        chk($sformatf("resp_err%0d", d), {31'd0, rerr[d]}, {31'd0, c_ee});
        if (rvalid[d]) begin
          last_resp[d] = cyc;
          pulse_cnt[d]++;
        end
        if (c_ev) void'(pq.pop_front());
        if (valid[d] && c_er) begin
          model(d[0], fcn, typ, addr, wdata, m_d, m_e);
          pq.push_back('{d: d[0], due: cyc + LAT[d], data: m_d, err: m_e});
          busy_until[d] = cyc + LAT[d];
          acc_cnt[d]++;
          last_acc[d]   = cyc;
          last_exp_data = m_d;
          last_exp_err  = m_e;
          if (d == 0) acc_hist.push_back(cyc);
        end
      end
      if (!rst_n) begin
        pq.delete();
        busy_until[0] = -1;
        busy_until[1] = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit d, input logic f, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] wd);
    int n0, k;
    n0 = acc_cnt[d];
    addr = a; wdata = wd; fcn = f; typ = t;
    valid[d] = 1'b1;
    k = 0;
    while ((acc_cnt[d] == n0) && (k < 50)) begin tick(); k++; end
    valid[d] = 1'b0;
    if (acc_cnt[d] == n0) begin
      tests++; fails++;
      $display("FAIL accept_timeout dut%0d: no acceptance within 50 cycles", d);
    end
    k = 0;
    while ((pq.size() > 0) && (k < 50)) begin tick(); k++; end
    if (pq.size() > 0) begin
      tests++; fails++;
      $display("FAIL resp_timeout dut%0d: response still pending", d);
    end
  endtask

  // Issue a word access on dut0 and pull reset one cycle after acceptance.
  task automatic req_rst(input logic f, input logic [31:0] a, input logic [31:0] wd);
    int n0, p0, k;
    n0 = acc_cnt[0];
    addr = a; wdata = wd; fcn = f; typ = MT_W;
    valid[0] = 1'b1;
    k = 0;
    while ((acc_cnt[0] == n0) && (k < 50)) begin tick(); k++; end
    p0 = pulse_cnt[0];
    valid[0] = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, ready[0]}, 32'd1);
    tick(); tick(); tick();
    chk("no_resp_after_rst", 32'(pulse_cnt[0] - p0), 32'd0);
  endtask

  logic [31:0] initw [16];
  logic [31:0] ra;
  logic [2:0]  rt;
  logic        rf;
  bit          rd;
  int          n, k;

  initial begin
    rst_n = 1'b0; valid = 2'b00; addr = '0; wdata = '0; fcn = 1'b0; typ = MT_W;
    tick(); tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      initw[i] = $urandom;
      do_req(1'b0, M_XWR, MT_W, 32'(i * 4), initw[i]);
      do_req(1'b1, M_XWR, MT_W, 32'(i * 4), $urandom);
    end

    // Word store then load, latency 2.
    do_req(1'b0, M_XWR, MT_W, 32'h10, 32'hDEAD_BEEF);
    chk("sw_latency", 32'(last_resp[0] - last_acc[0]), 32'd2);
    do_req(1'b0, M_XRD, MT_W, 32'h10, 32'h0);
    chk("lw_latency", 32'(last_resp[0] - last_acc[0]), 32'd2);
    chk("lw_model", last_exp_data, 32'hDEAD_BEEF);

    // Sub-word loads.
    do_req(1'b0, M_XWR, MT_W, 32'h20, 32'h80FF_7F01);
    do_req(1'b0, M_XRD, MT_B, 32'h23, 32'h0);
    chk("lb_model", last_exp_data, 32'hFFFF_FF80);
    do_req(1'b0, M_XRD, MT_BU, 32'h23, 32'h0);
    chk("lbu_model", last_exp_data, 32'h0000_0080);
    do_req(1'b0, M_XRD, MT_H, 32'h20, 32'h0);
    chk("lh_model", last_exp_data, 32'h0000_7F01);
    do_req(1'b0, M_XRD, MT_HU, 32'h22, 32'h0);
    chk("lhu_model", last_exp_data, 32'h0000_80FF);

    // Faults.
    do_req(1'b0, M_XRD, MT_W, 32'h22, 32'h0);
    chk("misal_err_model", {31'd0, last_exp_err}, 32'd1);
    do_req(1'b0, M_XRD, MT_W, 32'h20, 32'h0);
    chk("misal_nochange", last_exp_data, 32'h80FF_7F01);
    do_req(1'b0, M_XWR, MT_W, 32'h400, 32'h5555_AAAA);
    chk("oor_err_model", {31'd0, last_exp_err}, 32'd1);
    do_req(1'b0, M_XRD, MT_W, 32'h0, 32'h0);
    chk("oor_no_alias", last_exp_data, initw[0]);

    // Back-to-back with valid held high.
    n = acc_cnt[0];
    addr = 32'h10; fcn = M_XRD; typ = MT_W; valid[0] = 1'b1;
    k = 0;
    while ((acc_cnt[0] < n + 3) && (k < 100)) begin tick(); k++; end
    valid[0] = 1'b0;
    chk("b2b_count", 32'(acc_cnt[0] - n), 32'd3);
    n = acc_hist.size();
    if (n >= 3) begin
      chk("b2b_gap1", 32'(acc_hist[n-2] - acc_hist[n-3]), 32'd3);
      chk("b2b_gap2", 32'(acc_hist[n-1] - acc_hist[n-2]), 32'd3);
    end
    k = 0;
    while ((pq.size() > 0) && (k < 20)) begin tick(); k++; end

    // Reset mid-operation: load aborted, committed store survives.
    req_rst(M_XRD, 32'h10, 32'h0);
    req_rst(M_XWR, 32'h14, 32'h1234_5678);
    do_req(1'b0, M_XRD, MT_W, 32'h14, 32'h0);
    chk("rst_store_kept", last_exp_data, 32'h1234_5678);

    // Latency 1.
    do_req(1'b1, M_XWR, MT_W, 32'h30, 32'h1122_3344);
    do_req(1'b1, M_XWR, MT_B, 32'h31, 32'h0000_00AB);
    chk("sb_latency1", 32'(last_resp[1] - last_acc[1]), 32'd1);
    do_req(1'b1, M_XRD, MT_W, 32'h30, 32'h0);
    chk("lw_latency1", 32'(last_resp[1] - last_acc[1]), 32'd1);
    chk("sb_lane_model", last_exp_data, 32'h1122_AB44);

    // Randomised traffic on both DUTs.
    for (int i = 0; i < 120; i++) begin
      rd = 1'($urandom_range(0, 1));
      rf = 1'($urandom_range(0, 1));
      rt = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ra = 32'h400 + 32'($urandom_range(0, 4095));
      else                           ra = 32'($urandom_range(0, 63));
      do_req(rd, rf, rt, ra, $urandom);
      repeat ($urandom_range(0, 2)) tick();
    end

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
